// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_pkg
//  Purpose  : Shared types, operator codes and key-map decode for the keypad
//             front end and the calculator controller.
//  Contents : scan_state_t  - scanner FSM state encoding
//             OP_*          - operator codes (one-hot, OP_NONE = all zero)
//             key_info_t    - decoded meaning of one key position
//             decode_key()  - (row, col) -> key_info_t
//  Revision : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN         = 2'd0,
        DEBOUNCE     = 2'd1,
        EMIT         = 2'd2,
        WAIT_RELEASE = 2'd3
    } scan_state_t;

    localparam logic [2:0] OP_NONE = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_MULT = 3'b100;

    typedef enum logic [2:0] {
        KEY_NONE  = 3'd0,
        KEY_DIGIT = 3'd1,
        KEY_OP    = 3'd2,
        KEY_EQUAL = 3'd3,
        KEY_CLEAR = 3'd4
    } key_kind_t;

    typedef struct packed {
        key_kind_t  kind;
        logic [3:0] digit;
        logic [2:0] op;
    } key_info_t;

    // Key map, rows top to bottom:
    //   r0: 1 2 3 +   r1: 4 5 6 -   r2: 7 8 9 *   r3: C 0 = (unused)
    function automatic key_info_t decode_key(input logic [1:0] row,
                                             input logic [1:0] col);
        key_info_t k;
        k.kind  = KEY_NONE;
        k.digit = 4'd0;
        k.op    = OP_NONE;
        case ({row, col})
            4'h0: begin k.kind = KEY_DIGIT; k.digit = 4'd1; end
            4'h1: begin k.kind = KEY_DIGIT; k.digit = 4'd2; end
            4'h2: begin k.kind = KEY_DIGIT; k.digit = 4'd3; end
            4'h3: begin k.kind = KEY_OP;    k.op    = OP_ADD;  end
            4'h4: begin k.kind = KEY_DIGIT; k.digit = 4'd4; end
            4'h5: begin k.kind = KEY_DIGIT; k.digit = 4'd5; end
            4'h6: begin k.kind = KEY_DIGIT; k.digit = 4'd6; end
            4'h7: begin k.kind = KEY_OP;    k.op    = OP_SUB;  end
            4'h8: begin k.kind = KEY_DIGIT; k.digit = 4'd7; end
            4'h9: begin k.kind = KEY_DIGIT; k.digit = 4'd8; end
            4'hA: begin k.kind = KEY_DIGIT; k.digit = 4'd9; end
            4'hB: begin k.kind = KEY_OP;    k.op    = OP_MULT; end
            4'hC: k.kind = KEY_CLEAR;
            4'hD: begin k.kind = KEY_DIGIT; k.digit = 4'd0; end
            4'hE: k.kind = KEY_EQUAL;
            default: k.kind = KEY_NONE;
        endcase
        return k;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// ============================================================================
//  Module   : sync2
//  Purpose  : Generic two-flop synchroniser for asynchronous level inputs.
//  Ports    : clk  - destination clock
//             nRST - asynchronous active-low reset (flops load RESET_VAL)
//             d    - asynchronous input bus
//             q    - synchronised output bus (two cycles of latency)
//  Revision : 1.0 - initial release
// ============================================================================
module sync2 #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             nRST,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_scanner
//  Purpose  : Scans a 4x4 active-low matrix keypad, debounces press and
//             release, and turns each accepted press into exactly one
//             calculator event.
//  Ports    : clk            - system clock
//             nRST           - asynchronous active-low reset
//             col_in[3:0]    - column returns, active-low, asynchronous
//             row_out[3:0]   - row drive, active-low, one row low at a time
//             keypad_input   - last digit, valid with read_input
//             read_input     - one-cycle digit strobe
//             operator_input - held operator code (OP_* in keypad_pkg)
//             equal_input    - one-cycle '=' strobe
//             clear_pulse    - one-cycle clear strobe
//  Revision : 1.0 - initial release
// ============================================================================
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 50000
) (
    input  logic       clk,
    input  logic       nRST,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] keypad_input,
    output logic       read_input,
    output logic [2:0] operator_input,
    output logic       equal_input,
    output logic       clear_pulse
);

    localparam int c_DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_DEB_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(SCAN_DIV - 1);
    localparam logic [c_DEB_W-1:0] c_DEB_LAST = c_DEB_W'(DEBOUNCE_CNT - 1);

    logic [3:0]         col_s;
    scan_state_t        r_state;
    logic [c_DIV_W-1:0] r_div;
    logic [c_DEB_W-1:0] r_cnt;
    logic [1:0]         r_row_idx;
    logic [1:0]         r_key_row;
    logic [1:0]         r_key_col;
    logic [1:0]         w_low_col;
    key_info_t          w_key;

    sync2 #(
        .WIDTH     (4),
        .RESET_VAL (4'hF)
    ) u_col_sync (
        .clk  (clk),
        .nRST (nRST),
        .d    (col_in),
        .q    (col_s)
    );

    // Lowest-indexed low column wins when several keys share the row.
    always_comb begin
        w_low_col = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!col_s[i]) w_low_col = 2'(i);
        end
    end

    assign w_key = decode_key(r_key_row, r_key_col);

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_state        <= SCAN;
            r_div          <= '0;
            r_cnt          <= '0;
            r_row_idx      <= 2'd0;
            row_out        <= 4'b1110;
            r_key_row      <= 2'd0;
            r_key_col      <= 2'd0;
            keypad_input   <= 4'd0;
            read_input     <= 1'b0;
            operator_input <= OP_NONE;
            equal_input    <= 1'b0;
            clear_pulse    <= 1'b0;
        end else begin
            // Strobes are single-cycle; only EMIT raises them.
            read_input  <= 1'b0;
            equal_input <= 1'b0;
            clear_pulse <= 1'b0;

            case (r_state)
                SCAN: begin
                    if (r_div == c_DIV_LAST) begin
                        r_div <= '0;
                        if (col_s != 4'hF) begin
                            r_key_row <= r_row_idx;
                            r_key_col <= w_low_col;
                            r_cnt     <= '0;
                            r_state   <= DEBOUNCE;
                        end else begin
                            r_row_idx <= r_row_idx + 2'd1;
                            row_out   <= {row_out[2:0], row_out[3]};
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end

                DEBOUNCE: begin
                    // Only the latched column matters; a bounce back high
                    // drops the candidate and resumes scanning.
                    if (col_s[r_key_col]) begin
                        r_div     <= '0;
                        r_row_idx <= r_row_idx + 2'd1;
                        row_out   <= {row_out[2:0], row_out[3]};
                        r_state   <= SCAN;
                    end else if (r_cnt == c_DEB_LAST) begin
                        r_cnt   <= '0;
                        r_state <= EMIT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                EMIT: begin
                    case (w_key.kind)
                        KEY_DIGIT: begin
                            keypad_input <= w_key.digit;
                            read_input   <= 1'b1;
                        end
                        KEY_OP:    operator_input <= w_key.op;
                        KEY_EQUAL: equal_input    <= 1'b1;
                        KEY_CLEAR: begin
                            clear_pulse    <= 1'b1;
                            operator_input <= OP_NONE;
                        end
                        default: ;
                    endcase
                    r_cnt   <= '0;
                    r_state <= WAIT_RELEASE;
                end

                WAIT_RELEASE: begin
                    // Any low column (including other keys) restarts the
                    // release window, so nothing new is seen until all up.
                    if (col_s != 4'hF) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_DEB_LAST) begin
                        r_cnt     <= '0;
                        r_div     <= '0;
                        r_row_idx <= r_row_idx + 2'd1;
                        row_out   <= {row_out[2:0], row_out[3]};
                        r_state   <= SCAN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: r_state <= SCAN;
            endcase
        end
    end

endmodule
`default_nettype wire
